// File: rtl/rs_pkg.sv
// rs_pkg: constants and default entry layout shared by the RS, LSB and ROB.
package rs_pkg;
  localparam int OPENUM_NOP = 0;
  localparam int ZERO_ROB = 0;
  localparam int RS_DEPTH = 16;
  localparam int RS_NUM_CDB = 3;
  localparam int RS_ROB_W = 4;
  localparam int RS_DATA_W = 32;
  localparam int RS_OP_W = 6;
  typedef struct packed {
    logic busy;
    logic [RS_OP_W-1:0] op;
    logic [RS_ROB_W-1:0] rob;
    logic [RS_DATA_W-1:0] val1;
    logic [RS_DATA_W-1:0] val2;
    logic [RS_ROB_W-1:0] tag1;
    logic [RS_ROB_W-1:0] tag2;
    logic [RS_DATA_W-1:0] imm;
    logic [RS_DATA_W-1:0] pc;
  } rs_entry_t;
  function automatic int rank_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/rs_age_select.sv
// rs_age_select: finds the ready entry with the lowest age rank.
module rs_age_select #(
  parameter int DEPTH = 16,
  parameter int RW = 4
) (
  input  logic [DEPTH-1:0]    ready,
  input  logic [DEPTH*RW-1:0] ranks,
  output logic                found,
  output logic [RW-1:0]       idx,
  output logic [DEPTH-1:0]    oh
);
  logic [RW-1:0] best;
  always_comb begin
    found = 1'b0;
    idx = '0;
    best = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ready[i] && (!found || ranks[i*RW +: RW] < best)) begin
        found = 1'b1;
        idx = RW'(i);
        best = ranks[i*RW +: RW];
      end
    oh = found ? DEPTH'(1) << idx : '0;
  end
endmodule

// File: rtl/rs_age_queue.sv
// rs_age_queue: out-of-order issue queue with CDB wake-up and oldest-ready issue.
module rs_age_queue
  import rs_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH,
  parameter int NUM_CDB = RS_NUM_CDB,
  parameter int ROB_W = RS_ROB_W,
  parameter int DATA_W = RS_DATA_W,
  parameter int OP_W = RS_OP_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic                        flush,
  input  logic                        disp_valid,
  output logic                        disp_ready,
  input  logic [OP_W-1:0]             disp_op,
  input  logic [ROB_W-1:0]            disp_rob,
  input  logic [DATA_W-1:0]           disp_val1,
  input  logic [DATA_W-1:0]           disp_val2,
  input  logic [ROB_W-1:0]            disp_tag1,
  input  logic [ROB_W-1:0]            disp_tag2,
  input  logic [DATA_W-1:0]           disp_imm,
  input  logic [DATA_W-1:0]           disp_pc,
  input  logic [NUM_CDB-1:0]          cdb_valid,
  input  logic [NUM_CDB*ROB_W-1:0]    cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]   cdb_value,
  output logic                        iss_valid,
  input  logic                        iss_ready,
  output logic [OP_W-1:0]             iss_op,
  output logic [ROB_W-1:0]            iss_rob,
  output logic [DATA_W-1:0]           iss_val1,
  output logic [DATA_W-1:0]           iss_val2,
  output logic [DATA_W-1:0]           iss_imm,
  output logic [DATA_W-1:0]           iss_pc,
  output logic [$clog2(DEPTH+1)-1:0]  count
);
  localparam int RW = rank_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] busy, ready, sel_oh, free_oh;
  logic [OP_W-1:0] op_q [DEPTH];
  logic [ROB_W-1:0] rob_q [DEPTH];
  logic [DATA_W-1:0] val1_q [DEPTH], val2_q [DEPTH], imm_q [DEPTH], pc_q [DEPTH];
  logic [ROB_W-1:0] tag1_q [DEPTH], tag2_q [DEPTH];
  logic [RW-1:0] rank_q [DEPTH];
  logic [DATA_W-1:0] nv1 [DEPTH], nv2 [DEPTH];
  logic [ROB_W-1:0] nt1 [DEPTH], nt2 [DEPTH];
  logic [DATA_W-1:0] dv1, dv2;
  logic [ROB_W-1:0] dt1, dt2;
  logic [DEPTH*RW-1:0] rank_flat;
  logic [RW-1:0] sel_idx, free_idx;
  logic found, load, issue, fire;

  // Lowest-numbered valid bus wins when several broadcast the same tag.
  function automatic logic [ROB_W+DATA_W-1:0] fwd(input logic [ROB_W-1:0] t, input logic [DATA_W-1:0] v);
    fwd = {t, v};
    for (int k = NUM_CDB - 1; k >= 0; k--)
      if (cdb_valid[k] && t != ROB_W'(ZERO_ROB) && cdb_tag[k*ROB_W +: ROB_W] == t)
        fwd = {ROB_W'(ZERO_ROB), cdb_value[k*DATA_W +: DATA_W]};
  endfunction

  assign disp_ready = count < CW'(DEPTH);
  assign fire = disp_valid && disp_ready && disp_op != OP_W'(OPENUM_NOP) && disp_rob != ROB_W'(ZERO_ROB);
  assign load = !iss_valid || iss_ready;
  assign issue = load && found;
  assign {dt1, dv1} = fwd(disp_tag1, disp_val1);
  assign {dt2, dv2} = fwd(disp_tag2, disp_val2);

  always_comb begin
    rank_flat = '0;
    free_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = busy[i] && tag1_q[i] == ROB_W'(ZERO_ROB) && tag2_q[i] == ROB_W'(ZERO_ROB);
      rank_flat[i*RW +: RW] = rank_q[i];
      {nt1[i], nv1[i]} = fwd(tag1_q[i], val1_q[i]);
      {nt2[i], nv2[i]} = fwd(tag2_q[i], val2_q[i]);
    end
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!busy[i]) free_idx = RW'(i);
    free_oh = fire ? DEPTH'(1) << free_idx : '0;
  end

  rs_age_select #(.DEPTH(DEPTH), .RW(RW)) u_sel (
    .ready(ready),
    .ranks(rank_flat),
    .found(found),
    .idx(sel_idx),
    .oh(sel_oh)
  );

  // Payload and ranks carry no reset; busy gates their meaning.
  always_ff @(posedge clk) begin
    if (rdy && !flush)
      for (int i = 0; i < DEPTH; i++)
        if (fire && RW'(i) == free_idx) begin
          op_q[i] <= disp_op;
          rob_q[i] <= disp_rob;
          val1_q[i] <= dv1;
          val2_q[i] <= dv2;
          tag1_q[i] <= dt1;
          tag2_q[i] <= dt2;
          imm_q[i] <= disp_imm;
          pc_q[i] <= disp_pc;
          rank_q[i] <= RW'(count - CW'(issue));
        end else begin
          val1_q[i] <= nv1[i];
          val2_q[i] <= nv2[i];
          tag1_q[i] <= nt1[i];
          tag2_q[i] <= nt2[i];
          if (issue && rank_q[i] > rank_q[sel_idx]) rank_q[i] <= rank_q[i] - 1'b1;
        end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
      count <= '0;
      iss_valid <= 1'b0;
      iss_op <= '0;
      iss_rob <= '0;
      iss_val1 <= '0;
      iss_val2 <= '0;
      iss_imm <= '0;
      iss_pc <= '0;
    end else if (rdy) begin
      if (flush) begin
        busy <= '0;
        count <= '0;
        iss_valid <= 1'b0;
        iss_op <= '0;
      end else begin
        busy <= (busy & ~(issue ? sel_oh : '0)) | free_oh;
        count <= count + CW'(fire) - CW'(issue);
        if (load) begin
          iss_valid <= found;
          if (found) begin
            iss_op <= op_q[sel_idx];
            iss_rob <= rob_q[sel_idx];
            iss_val1 <= val1_q[sel_idx];
            iss_val2 <= val2_q[sel_idx];
            iss_imm <= imm_q[sel_idx];
            iss_pc <= pc_q[sel_idx];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_rs_age_queue.sv
// tb_rs_age_queue: directed stimulus checked against an age-ordered queue model.
module tb_rs_age_queue;
  localparam int DEPTH = 16, NUM_CDB = 3, ROB_W = 4, DATA_W = 32, OP_W = 6, CW = 5;

  logic clk, rst, rdy, flush, disp_valid, disp_ready, iss_valid, iss_ready;
  logic [OP_W-1:0] disp_op, iss_op;
  logic [ROB_W-1:0] disp_rob, disp_tag1, disp_tag2, iss_rob;
  logic [DATA_W-1:0] disp_val1, disp_val2, disp_imm, disp_pc;
  logic [DATA_W-1:0] iss_val1, iss_val2, iss_imm, iss_pc;
  logic [NUM_CDB-1:0] cdb_valid;
  logic [NUM_CDB*ROB_W-1:0] cdb_tag;
  logic [NUM_CDB*DATA_W-1:0] cdb_value;
  logic [CW-1:0] count;

  rs_age_queue dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op), .disp_rob(disp_rob),
    .disp_val1(disp_val1), .disp_val2(disp_val2), .disp_tag1(disp_tag1), .disp_tag2(disp_tag2),
    .disp_imm(disp_imm), .disp_pc(disp_pc),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op), .iss_rob(iss_rob),
    .iss_val1(iss_val1), .iss_val2(iss_val2), .iss_imm(iss_imm), .iss_pc(iss_pc),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: entries kept oldest-first in a queue; the issue register is a plain record.
  typedef struct {
    logic [OP_W-1:0] op;
    logic [ROB_W-1:0] rob, t1, t2;
    logic [DATA_W-1:0] v1, v2, imm, pc;
  } ent_t;
  ent_t q[$];
  ent_t ei, ne;
  logic ev;
  int sel;
  bit fire;

  function automatic void wake(input logic [ROB_W-1:0] t, input logic [DATA_W-1:0] v,
                               output logic [ROB_W-1:0] nt, output logic [DATA_W-1:0] nv);
    nt = t;
    nv = v;
    for (int k = 0; k < NUM_CDB; k++)
      if (nt != 0 && cdb_valid[k] && cdb_tag[k*ROB_W +: ROB_W] == nt) begin
        nt = 0;
        nv = cdb_value[k*DATA_W +: DATA_W];
      end
  endfunction

  initial begin
    ev = 1'b0;
    ei = '{default: '0};
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        ev = 1'b0;
        ei = '{default: '0};
      end else if (rdy) begin
        if (flush) begin
          q.delete();
          ev = 1'b0;
          ei.op = '0;
        end else begin
          fire = disp_valid && q.size() < DEPTH && disp_op != 0 && disp_rob != 0;
          if (!ev || iss_ready) begin
            sel = -1;
            foreach (q[i]) if (sel < 0 && q[i].t1 == 0 && q[i].t2 == 0) sel = i;
            ev = sel >= 0;
            if (sel >= 0) begin
              ei = q[sel];
              q.delete(sel);
            end
          end
          foreach (q[i]) begin
            wake(q[i].t1, q[i].v1, q[i].t1, q[i].v1);
            wake(q[i].t2, q[i].v2, q[i].t2, q[i].v2);
          end
          if (fire) begin
            ne.op = disp_op;
            ne.rob = disp_rob;
            ne.imm = disp_imm;
            ne.pc = disp_pc;
            wake(disp_tag1, disp_val1, ne.t1, ne.v1);
            wake(disp_tag2, disp_val2, ne.t2, ne.v2);
            q.push_back(ne);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_count", 32'(count), q.size());
      chk("m_disp_ready", 32'(disp_ready), 32'(q.size() < DEPTH));
      chk("m_iss_valid", 32'(iss_valid), 32'(ev));
      if (ev) begin
        chk("m_iss_op", 32'(iss_op), 32'(ei.op));
        chk("m_iss_rob", 32'(iss_rob), 32'(ei.rob));
        chk("m_iss_val1", iss_val1, ei.v1);
        chk("m_iss_val2", iss_val2, ei.v2);
        chk("m_iss_imm", iss_imm, ei.imm);
        chk("m_iss_pc", iss_pc, ei.pc);
      end
    end
  end

  task automatic disp(input logic [OP_W-1:0] op, input logic [ROB_W-1:0] rob,
                      input logic [ROB_W-1:0] t1, input logic [DATA_W-1:0] v1,
                      input logic [ROB_W-1:0] t2, input logic [DATA_W-1:0] v2);
    disp_valid = 1'b1;
    disp_op = op;
    disp_rob = rob;
    disp_tag1 = t1;
    disp_val1 = v1;
    disp_tag2 = t2;
    disp_val2 = v2;
    disp_imm = v1 + 32'd1;
    disp_pc = 32'h1000 + 32'(rob);
    @(negedge clk);
    disp_valid = 1'b0;
    cdb_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; iss_ready = 1'b1;
    disp_valid = 1'b0; disp_op = '0; disp_rob = '0; disp_tag1 = '0; disp_tag2 = '0;
    disp_val1 = '0; disp_val2 = '0; disp_imm = '0; disp_pc = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(count), 0);
    chk("rst_iss_valid", 32'(iss_valid), 0);
    chk("rst_iss_op", 32'(iss_op), 0);
    chk("rst_iss_rob", 32'(iss_rob), 0);
    chk("rst_iss_val1", iss_val1, 0);
    chk("rst_disp_ready", 32'(disp_ready), 1);
    rst = 1'b0;
    // single ready op: visible after the second edge
    disp(6'd5, 4'd3, 4'd0, 32'd10, 4'd0, 32'd20);
    chk("t1_count", 32'(count), 1);
    chk("t1_not_yet", 32'(iss_valid), 0);
    @(negedge clk);
    chk("t1_valid", 32'(iss_valid), 1);
    chk("t1_rob", 32'(iss_rob), 3);
    chk("t1_val1", iss_val1, 10);
    chk("t1_val2", iss_val2, 20);
    chk("t1_count0", 32'(count), 0);
    // younger ready op bypasses older waiting one
    disp(6'd9, 4'd1, 4'd7, 32'd0, 4'd0, 32'd2);
    disp(6'd10, 4'd2, 4'd0, 32'd3, 4'd0, 32'd4);
    @(negedge clk);
    chk("t2_b_first", 32'(iss_rob), 2);
    cdb_valid = 3'b100;
    cdb_tag[8 +: 4] = 4'd7;
    cdb_value[64 +: 32] = 32'hAB;
    @(negedge clk);
    cdb_valid = '0;
    chk("t2_gap", 32'(iss_valid), 0);
    @(negedge clk);
    chk("t2_a_rob", 32'(iss_rob), 1);
    chk("t2_a_val1", iss_val1, 32'hAB);
    // dispatch-time forwarding from bus 1
    cdb_valid = 3'b010;
    cdb_tag[4 +: 4] = 4'd4;
    cdb_value[32 +: 32] = 32'd99;
    disp(6'd11, 4'd6, 4'd0, 32'd5, 4'd4, 32'd0);
    @(negedge clk);
    chk("t3_rob", 32'(iss_rob), 6);
    chk("t3_val2", iss_val2, 99);
    // fill with the issue register stalled
    iss_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      disp(6'(i + 1), 4'((i % 15) + 1), 4'd0, 32'(100 + i), 4'd0, 32'(200 + i));
    chk("t4_full", 32'(count), DEPTH);
    chk("t4_not_ready", 32'(disp_ready), 0);
    disp(6'd40, 4'd9, 4'd0, 32'd1, 4'd0, 32'd1);
    chk("t4_refused", 32'(count), DEPTH);
    chk("t4_hold", 32'(iss_rob), 6);
    iss_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      chk("t4_order", 32'(iss_op), 32'(i + 1));
    end
    @(negedge clk);
    chk("t4_drained", 32'(iss_valid), 0);
    chk("t4_empty", 32'(count), 0);
    // flush beats dispatch and CDB in the same cycle
    iss_ready = 1'b0;
    for (int i = 0; i < 4; i++) disp(6'(20 + i), 4'(i + 1), 4'd0, 32'(i), 4'd0, 32'(i));
    chk("t5_loaded", 32'(count), 3);
    flush = 1'b1;
    cdb_valid = 3'b001;
    cdb_tag[0 +: 4] = 4'd2;
    disp(6'd30, 4'd4, 4'd0, 32'd1, 4'd0, 32'd1);
    flush = 1'b0;
    chk("t5_count", 32'(count), 0);
    chk("t5_valid", 32'(iss_valid), 0);
    chk("t5_op", 32'(iss_op), 0);
    iss_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_quiet", 32'(iss_valid), 0);
    // rdy low freezes everything
    disp(6'd7, 4'd5, 4'd0, 32'd55, 4'd0, 32'd66);
    rdy = 1'b0;
    cdb_valid = 3'b001;
    cdb_tag[0 +: 4] = 4'd3;
    disp_valid = 1'b1; disp_op = 6'd8; disp_rob = 4'd6; disp_tag1 = 4'd3; disp_tag2 = 4'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_frozen_valid", 32'(iss_valid), 0);
      chk("t6_frozen_count", 32'(count), 1);
    end
    disp_valid = 1'b0;
    cdb_valid = '0;
    rdy = 1'b1;
    @(negedge clk);
    chk("t6_resume_valid", 32'(iss_valid), 1);
    chk("t6_resume_rob", 32'(iss_rob), 5);
    chk("t6_resume_val1", iss_val1, 55);
    @(negedge clk);
    chk("t6_done", 32'(count), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
